// File: rtl/da_fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : da_fir_pkg
//  Description : Shared constants and helper functions for the parametrised
//                distributed-arithmetic FIR filter: ceil(log2), accumulator
//                width, FSM state encoding and the partial-sum table builder.
//  Revision    : 1.0  initial release
// ============================================================================
package da_fir_pkg;

    // Widest packed coefficient vector the table builder accepts
    // (16 taps of up to 32-bit coefficients).
    localparam int MAX_COEFF_BITS = 512;
    // Working width of a table entry before it is cut to the LUT output width.
    localparam int LUT_W = 64;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // One guard bit on top of the exact worst-case product-sum width.
    function automatic int acc_width(input int x_w, input int c_w, input int n_taps);
        return x_w + c_w + clog2(n_taps) + 1;
    endfunction

    // Sum of the coefficients of taps group*4 .. group*4+3 whose address bit
    // is set. Taps at or beyond n_taps contribute nothing, so a short last
    // group behaves as if its missing address bits were tied low.
    function automatic logic signed [LUT_W-1:0] lut_entry(
        input logic [MAX_COEFF_BITS-1:0] coeffs,
        input int                        n_taps,
        input int                        c_w,
        input int                        group,
        input logic [3:0]                addr
    );
        logic signed [LUT_W-1:0] sum;
        logic signed [LUT_W-1:0] coef;
        sum = '0;
        for (int k = 0; k < 4; k++) begin
            if (addr[k] && ((group * 4 + k) < n_taps)) begin
                // Move the field to the top, then shift back arithmetically
                // to sign-extend a c_w-bit coefficient.
                coef = $signed(LUT_W'(coeffs >> ((group * 4 + k) * c_w)) << (LUT_W - c_w))
                       >>> (LUT_W - c_w);
                sum  = sum + coef;
            end
        end
        return sum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/da_lut4.sv
`default_nettype none
// ============================================================================
//  Module      : da_lut4
//  Description : Combinational 16-entry partial-sum table covering four taps
//                (taps GROUP*4 .. GROUP*4+3) of the DA FIR filter.
//  Ports       : addr  in  4      one bit per tap, bit 0 = lowest tap
//                psum  out OUT_W  signed sum of selected coefficients
//  Revision    : 1.0  initial release
// ============================================================================
module da_lut4
    import da_fir_pkg::*;
#(
    parameter int                      N_TAPS = 8,
    parameter int                      C_W    = 8,
    parameter int                      GROUP  = 0,
    parameter int                      OUT_W  = 20,
    parameter logic [N_TAPS*C_W-1:0]   COEFFS = '0
) (
    input  logic [3:0]              addr,
    output logic signed [OUT_W-1:0] psum
);

    localparam logic [MAX_COEFF_BITS-1:0] c_coeffs = MAX_COEFF_BITS'(COEFFS);

    logic signed [OUT_W-1:0] w_table [16];

    for (genvar e = 0; e < 16; e++) begin : g_entry
        localparam logic signed [LUT_W-1:0] c_val =
            lut_entry(c_coeffs, N_TAPS, C_W, GROUP, 4'(e));
        assign w_table[e] = c_val[OUT_W-1:0];
    end

    assign psum = w_table[addr];

endmodule
`default_nettype wire

// File: rtl/da_fir_param.sv
`default_nettype none
// ============================================================================
//  Module      : da_fir_param
//  Description : Parametrised distributed-arithmetic FIR filter. Consumes L
//                bits of every delay-line sample per cycle, MSB slice first,
//                and produces one scaled / optionally saturated output per
//                accepted sample.
//  Ports       : clk        in   1     clock, rising edge
//                RstN       in   1     asynchronous active-low reset
//                in_valid   in   1     X holds a sample
//                in_ready   out  1     high while idle
//                X          in   X_W   signed input sample
//                flush      in   1     zero the delay line (idle only)
//                Yn         out  Y_W   registered signed output
//                out_valid  out  1     one-cycle strobe, Yn updated
//  Revision    : 1.0  initial release
// ============================================================================
module da_fir_param
    import da_fir_pkg::*;
#(
    parameter int                    N_TAPS = 8,
    parameter int                    X_W    = 8,
    parameter int                    C_W    = 8,
    parameter int                    Y_W    = 16,
    parameter int                    L      = 1,
    parameter logic [N_TAPS*C_W-1:0] COEFFS = {8'sd1, 8'sd2, 8'sd3, 8'sd4,
                                               8'sd4, 8'sd3, 8'sd2, 8'sd1},
    parameter int                    SHIFT  = 0,
    parameter int                    SAT    = 1
) (
    input  logic                  clk,
    input  logic                  RstN,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [X_W-1:0] X,
    input  logic                  flush,
    output logic signed [Y_W-1:0] Yn,
    output logic                  out_valid
);

    localparam int c_acc_w   = acc_width(X_W, C_W, N_TAPS);
    localparam int c_n_grp   = (N_TAPS + 3) / 4;
    localparam int c_n_slice = X_W / L;
    localparam int c_cnt_w   = clog2(c_n_slice + 1);
    localparam int c_cmp_w   = ((c_acc_w > Y_W) ? c_acc_w : Y_W) + 1;

    localparam logic [c_cnt_w-1:0]        c_last = c_cnt_w'(c_n_slice - 1);
    localparam logic signed [c_cmp_w-1:0] c_ymax = {{(c_cmp_w-Y_W+1){1'b0}}, {(Y_W-1){1'b1}}};
    localparam logic signed [c_cmp_w-1:0] c_ymin = {{(c_cmp_w-Y_W+1){1'b1}}, {(Y_W-1){1'b0}}};

    state_t                    r_state;
    logic [X_W-1:0]            r_x [N_TAPS];
    logic signed [c_acc_w-1:0] r_acc;
    logic [c_cnt_w-1:0]        r_cnt;
    logic signed [Y_W-1:0]     r_yn;
    logic                      r_out_valid;

    logic signed [c_acc_w-1:0] w_p [L][c_n_grp];
    logic signed [c_acc_w-1:0] w_sum;
    logic signed [c_acc_w-1:0] w_acc_next;
    logic signed [c_cmp_w-1:0] w_ext;
    logic signed [c_cmp_w-1:0] w_r;
    logic signed [Y_W-1:0]     w_y;

    // During RUN every delay-line word is rotated left by L, so the slice
    // being processed always sits in the top L bits. After X_W/L rotations
    // the words are back in their original orientation for the next sample.
    function automatic logic [X_W-1:0] rotl(input logic [X_W-1:0] a);
        return (a << L) | (a >> (X_W - L));
    endfunction

    for (genvar j = 0; j < L; j++) begin : g_slice
        for (genvar g = 0; g < c_n_grp; g++) begin : g_group
            logic [3:0] w_addr;
            for (genvar k = 0; k < 4; k++) begin : g_bit
                if ((g * 4 + k) < N_TAPS) begin : g_tap
                    assign w_addr[k] = r_x[g*4+k][X_W-L+j];
                end else begin : g_pad
                    assign w_addr[k] = 1'b0;
                end
            end
            da_lut4 #(
                .N_TAPS (N_TAPS),
                .C_W    (C_W),
                .GROUP  (g),
                .OUT_W  (c_acc_w),
                .COEFFS (COEFFS)
            ) u_lut (
                .addr (w_addr),
                .psum (w_p[j][g])
            );
        end
    end

    // Bit j of the slice carries weight 2^j; the very first slice holds the
    // sign bit (top bit of the top slice), which carries negative weight.
    always_comb begin
        w_sum = '0;
        for (int j = 0; j < L; j++) begin
            for (int g = 0; g < c_n_grp; g++) begin
                if ((r_cnt == '0) && (j == L - 1)) begin
                    w_sum = w_sum - (w_p[j][g] <<< j);
                end else begin
                    w_sum = w_sum + (w_p[j][g] <<< j);
                end
            end
        end
    end

    assign w_acc_next = (r_acc <<< L) + w_sum;
    assign w_ext      = {{(c_cmp_w-c_acc_w){w_acc_next[c_acc_w-1]}}, w_acc_next};
    assign w_r        = w_ext >>> SHIFT;

    always_comb begin
        w_y = w_r[Y_W-1:0];
        if (SAT != 0) begin
            if (w_r > c_ymax) begin
                w_y = c_ymax[Y_W-1:0];
            end else if (w_r < c_ymin) begin
                w_y = c_ymin[Y_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge RstN) begin
        if (!RstN) begin
            r_state <= ST_IDLE;
            for (int t = 0; t < N_TAPS; t++) r_x[t] <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_yn        <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (flush) begin
                        for (int t = 0; t < N_TAPS; t++) r_x[t] <= '0;
                    end else if (in_valid) begin
                        r_x[0] <= X;
                        for (int t = 1; t < N_TAPS; t++) r_x[t] <= r_x[t-1];
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int t = 0; t < N_TAPS; t++) r_x[t] <= rotl(r_x[t]);
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + c_cnt_w'(1);
                    if (r_cnt == c_last) begin
                        r_yn        <= w_y;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign Yn        = r_yn;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_da_fir_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_da_fir_param
//  Description : Self-checking bench for da_fir_param. Seven filter
//                configurations share clock and reset; each has its own
//                handshake. Expected outputs come from a direct convolution
//                model (sum of coeff*sample, shift, clamp or wrap).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_da_fir_param;

    localparam int N_DUT = 7;
    localparam logic [63:0] c_def_coeffs = {8'sd1, 8'sd2, 8'sd3, 8'sd4,
                                            8'sd4, 8'sd3, 8'sd2, 8'sd1};
    localparam logic [29:0] c_odd_coeffs = {6'sd31, 6'b100000, 6'sd7, -6'sd5, 6'sd13};

    function automatic int cfg_l(input int i);
        case (i)
            1: return 2;
            2: return 4;
            3: return 8;
            default: return 1;
        endcase
    endfunction

    function automatic int cfg_yw(input int i);
        return (i == 4 || i == 5) ? 8 : 16;
    endfunction

    function automatic int cfg_sat(input int i);
        return (i == 5) ? 0 : 1;
    endfunction

    logic             clk;
    logic             RstN;
    logic [N_DUT-1:0] vld;
    logic [N_DUT-1:0] fl;
    logic [N_DUT-1:0] rdy;
    logic [N_DUT-1:0] ov;
    logic [7:0]       xin [N_DUT];
    longint           yx  [N_DUT];

    for (genvar gi = 0; gi < 6; gi++) begin : g_dut
        localparam int P_L   = cfg_l(gi);
        localparam int P_YW  = cfg_yw(gi);
        localparam int P_SAT = cfg_sat(gi);
        logic signed [P_YW-1:0] y;
        da_fir_param #(
            .N_TAPS (8), .X_W (8), .C_W (8), .Y_W (P_YW), .L (P_L),
            .COEFFS (c_def_coeffs), .SHIFT (0), .SAT (P_SAT)
        ) u_dut (
            .clk (clk), .RstN (RstN), .in_valid (vld[gi]), .in_ready (rdy[gi]),
            .X (xin[gi]), .flush (fl[gi]), .Yn (y), .out_valid (ov[gi])
        );
        assign yx[gi] = longint'(y);
    end

    logic signed [11:0] y6;
    da_fir_param #(
        .N_TAPS (5), .X_W (8), .C_W (6), .Y_W (12), .L (4),
        .COEFFS (c_odd_coeffs), .SHIFT (2), .SAT (1)
    ) u_dut6 (
        .clk (clk), .RstN (RstN), .in_valid (vld[6]), .in_ready (rdy[6]),
        .X (xin[6]), .flush (fl[6]), .Yn (y6), .out_valid (ov[6])
    );
    assign yx[6] = longint'(y6);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    longint hist [N_DUT][16];
    int     mc   [N_DUT][8];
    int     m_nt [N_DUT];
    int     m_sh [N_DUT];
    int     m_sat[N_DUT];
    int     m_yw [N_DUT];
    int     m_lat[N_DUT];

    int n_vec;
    int n_err;

    task automatic model_push(input int i, input int x);
        for (int k = 15; k > 0; k--) hist[i][k] = hist[i][k-1];
        hist[i][0] = longint'(x);
    endtask

    task automatic model_clear(input int i);
        for (int k = 0; k < 16; k++) hist[i][k] = 0;
    endtask

    function automatic longint model_out(input int i);
        longint acc, r, lim;
        acc = 0;
        for (int k = 0; k < m_nt[i]; k++) acc += longint'(mc[i][k]) * hist[i][k];
        r   = acc >>> m_sh[i];
        lim = longint'(1) << (m_yw[i] - 1);
        if (m_sat[i] != 0) begin
            if (r > lim - 1)   r = lim - 1;
            else if (r < -lim) r = -lim;
        end else begin
            r = r & ((lim << 1) - 1);
            if (r >= lim) r = r - (lim << 1);
        end
        return r;
    endfunction

    task automatic check(input string tag, input longint obs, input longint exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Offer one sample to DUT i and follow it to its out_valid strobe.
    // keep: leave in_valid high afterwards (back-to-back streaming).
    // b2b : the previous call kept in_valid high, so no wait is expected.
    task automatic send(input int i, input int x, input bit keep, input bit b2b);
        int     waited;
        int     lat;
        longint exp;
        waited = 0;
        while (!rdy[i] && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        check($sformatf("ready_before_accept_dut%0d", i), longint'(rdy[i]), 1);
        if (b2b) check($sformatf("b2b_wait_dut%0d", i), longint'(waited), 0);
        vld[i] = 1'b1;
        xin[i] = 8'(x);
        @(posedge clk); #1;
        if (!keep) vld[i] = 1'b0;
        model_push(i, x);
        exp = model_out(i);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ov[i] && lat < 40);
        check($sformatf("latency_dut%0d", i), longint'(lat), longint'(m_lat[i]));
        check($sformatf("yn_dut%0d", i), yx[i], exp);
        check($sformatf("ready_with_ov_dut%0d", i), longint'(rdy[i]), 1);
        if (!keep) begin
            @(posedge clk); #1;
            check($sformatf("ov_one_cycle_dut%0d", i), longint'(ov[i]), 0);
            check($sformatf("yn_hold_dut%0d", i), yx[i], exp);
        end
    endtask

    task automatic flush_with_valid(input int i, input int x);
        bit seen;
        fl[i]  = 1'b1;
        vld[i] = 1'b1;
        xin[i] = 8'(x);
        @(posedge clk); #1;
        fl[i]  = 1'b0;
        vld[i] = 1'b0;
        check($sformatf("flush_not_accepted_dut%0d", i), longint'(rdy[i]), 1);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (ov[i]) seen = 1'b1;
        end
        check($sformatf("flush_no_ov_dut%0d", i), longint'(seen), 0);
        model_clear(i);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int imp_exp  [9];
        int step_exp [10];
        bit prev_keep;
        bit keep;
        bit seen;
        int x;

        imp_exp  = '{1, 2, 3, 4, 4, 3, 2, 1, 0};
        step_exp = '{127, 381, 762, 1270, 1778, 2159, 2413, 2540, 2540, 2540};
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < N_DUT; i++) begin
            model_clear(i);
            if (i < 6) begin
                mc[i]    = '{1, 2, 3, 4, 4, 3, 2, 1};
                m_nt[i]  = 8;
                m_sh[i]  = 0;
                m_sat[i] = cfg_sat(i);
                m_yw[i]  = cfg_yw(i);
                m_lat[i] = 8 / cfg_l(i);
            end else begin
                mc[i]    = '{13, -5, 7, -32, 31, 0, 0, 0};
                m_nt[i]  = 5;
                m_sh[i]  = 2;
                m_sat[i] = 1;
                m_yw[i]  = 12;
                m_lat[i] = 2;
            end
            xin[i] = '0;
        end
        vld  = '0;
        fl   = '0;
        RstN = 1'b0;

        // Reset state
        #22;
        for (int i = 0; i < N_DUT; i++) begin
            check($sformatf("rst_yn_dut%0d", i), yx[i], 0);
            check($sformatf("rst_ov_dut%0d", i), longint'(ov[i]), 0);
            check($sformatf("rst_ready_dut%0d", i), longint'(rdy[i]), 1);
        end
        @(negedge clk);
        RstN = 1'b1;
        @(posedge clk); #1;

        // Impulse and negative impulse on the default configuration
        for (int n = 0; n < 9; n++) begin
            send(0, (n == 0) ? 1 : 0, 1'b0, 1'b0);
            check("impulse_const", yx[0], longint'(imp_exp[n]));
        end
        for (int n = 0; n < 9; n++) send(0, (n == 0) ? -128 : 0, 1'b0, 1'b0);

        // Step 127, streamed back-to-back, for L = 1, 2, 4, 8
        for (int i = 0; i < 4; i++) begin
            for (int n = 0; n < 10; n++) begin
                send(i, 127, (n < 9), (n > 0));
                check($sformatf("step_const_dut%0d", i), yx[i], longint'(step_exp[n]));
            end
        end

        // Saturating and wrapping 8-bit outputs
        for (int n = 0; n < 10; n++) send(4, 127, 1'b0, 1'b0);
        for (int n = 0; n < 10; n++) send(4, -128, 1'b0, 1'b0);
        check("sat_neg_const", yx[4], -128);
        for (int n = 0; n < 3; n++) begin
            send(5, 127, 1'b0, 1'b0);
            if (n == 1) check("wrap_const", yx[5], 125);
        end

        // Flush: clear history, impulse, flush beats a valid sample, then zero
        flush_with_valid(0, 0);
        for (int n = 0; n < 3; n++) send(0, (n == 0) ? 1 : 0, 1'b0, 1'b0);
        flush_with_valid(0, 5);
        send(0, 0, 1'b0, 1'b0);
        check("after_flush_const", yx[0], 0);

        // Random samples on every configuration, mixed idle/streaming
        for (int i = 0; i < N_DUT; i++) begin
            prev_keep = 1'b0;
            for (int n = 0; n < 25; n++) begin
                x    = int'($urandom_range(0, 255)) - 128;
                keep = (n < 24) && ($urandom_range(0, 1) == 1);
                send(i, x, keep, prev_keep);
                prev_keep = keep;
            end
        end

        // Reset in the middle of a computation
        vld[0] = 1'b1;
        xin[0] = 8'd77;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        RstN = 1'b0;
        #1;
        check("midrst_yn", yx[0], 0);
        check("midrst_ov", longint'(ov[0]), 0);
        check("midrst_ready", longint'(rdy[0]), 1);
        @(negedge clk);
        RstN = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (ov != '0) seen = 1'b1;
        end
        check("midrst_no_ov", longint'(seen), 0);
        for (int i = 0; i < N_DUT; i++) model_clear(i);
        send(0, 1, 1'b0, 1'b0);
        check("midrst_impulse_const", yx[0], 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
